exc_commit: RTL
===============

Name: exc_commit

Overview:
- Exception/interrupt commit controller at the writeback boundary of the LoongArch pipeline.
- Arbitrates, for each instruction leaving WB, among interrupts, synchronous exceptions, ERTN, refetch-class instructions (TLB ops, IBAR) and IDLE.
- Drives the CSR unit's exception-report inputs and flushes the pipeline until the CSR unit answers with its redirect strobe (`exlike`).
- Also synchronises the external and IPI interrupt lines into the CSR `inter` vector, and owns the IDLE sleep state.

Parameters:
- SYNC_STAGES, 2, flops in each interrupt-line synchroniser (minimum 2).
- HOLD_MAX, 15, maximum HOLD cycles waiting for `exlike` before the watchdog fires.
- INT_EXCODE, 6'h00, excode reported for interrupts.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- ext_int  in  8  external hardware interrupt lines, asynchronous
- ipi_int  in  1  inter-processor interrupt line, asynchronous
- wb_valid  in  1  WB holds an instruction
- wb_pc  in  32  PC of the WB instruction
- wb_exc  in  1  WB instruction raised an exception
- wb_excode  in  6  exception code
- wb_esubcode  in  9  exception subcode
- wb_badv  in  32  faulting address
- wb_is_ertn  in  1  WB instruction is ERTN
- wb_refetch  in  1  WB instruction needs a refetch from pc+4
- wb_is_idle  in  1  WB instruction is IDLE
- wb_ack  out  1  WB instruction consumed this cycle (combinational)
- lie  in  12  CSR local interrupt enable
- is  in  12  CSR interrupt status
- ie  in  1  CSR global interrupt enable
- exlike  in  1  CSR redirect strobe
- inter  out  12  interrupt vector to the CSR unit
- is_exc  out  1  exception report to CSR
- excode  out  6  exception code to CSR
- esubcode  out  9  exception subcode to CSR
- badvaddr  out  32  faulting address to CSR
- csr_pc  out  32  PC of the reported instruction
- is_ertn  out  1  ERTN report
- is_fetch_again  out  1  refetch report
- is_idle  out  1  IDLE entry report
- flush  out  1  pipeline flush
- stall  out  1  hold the fetch/WB pipeline
- hold_timeout  out  1  sticky watchdog flag

Behaviour:
- **Reset (asynchronous):** every output register, every synchroniser flop, the state and the watchdog counter go to 0. State = RUN.
- **Interrupt synchroniser:**
  - Each line passes through SYNC_STAGES flops.
  - `inter` = {ipi_s, 1'b0, ext_s[7:0], 2'b00}, registered.
  - Bit 10 is always 0 (the timer is internal to the CSR unit); bits 1:0 are always 0 (software interrupts).
- **Interrupt pending:** `int_pend` = ie & |(lie & is), combinational.
- **Event outputs:**
  - `is_exc`, `is_ertn`, `is_fetch_again` and `is_idle` are registered single-cycle pulses.
  - Their payload (`excode`, `esubcode`, `badvaddr`, `csr_pc`) is registered and held until the next event.
  - An event decided in cycle N appears on the outputs in cycle N+1.
- **RUN state, when `wb_valid` = 1.** Fixed priority, first match wins:
  1. `int_pend` → is_exc, excode = INT_EXCODE, esubcode = 0, csr_pc = wb_pc. The instruction is not committed.
  2. `wb_exc` → is_exc with `wb_excode`, `wb_esubcode`, `wb_badv`, csr_pc = wb_pc.
  3. `wb_is_ertn` → is_ertn.
  4. `wb_refetch` → is_fetch_again, csr_pc = wb_pc.
  5. `wb_is_idle` → is_idle, csr_pc = wb_pc; go to IDLE.
  6. Otherwise the instruction commits normally.
- **RUN state, common rules:**
  - `wb_ack` = `wb_valid` whenever the state is RUN.
  - Outcomes 1–4 go to HOLD.
  - `flush` is asserted from the cycle after the decision until HOLD exits.
- **IDLE state:**
  - `stall` = 1, `wb_ack` = 0, `flush` = 0.
  - When `int_pend` = 1: emit is_exc INT with csr_pc = the latched IDLE pc, then go to HOLD. (The CSR unit derives ERA = idle pc + 4 itself.)
- **HOLD state:**
  - `wb_ack` = 0, all WB inputs are ignored, `flush` = 1, `stall` = 0.
  - A 4-bit counter increments each cycle in HOLD.
  - `exlike` = 1 → return to RUN next cycle and clear the counter.
  - Counter reaching HOLD_MAX without `exlike` → set `hold_timeout` (sticky until reset), return to RUN.
  - An `exlike` arriving in the same cycle HOLD is entered is ignored; HOLD lasts at least 1 cycle.
- **Out-of-state inputs:** `exlike` seen in RUN or IDLE is ignored. An interrupt arriving during HOLD stays pending and is taken at the next valid WB instruction in RUN.
- **Reset mid-HOLD or mid-IDLE:** state is discarded immediately; no pulse is emitted after reset deasserts.

Test Plan:
- **Synchronous exception:** wb_valid=1, wb_exc=1, excode=0x0B, wb_pc=0x1C000100, int_pend=0 → next cycle is_exc=1 for one cycle, excode=0x0B, csr_pc=0x1C000100, flush=1. flush stays 1 until exlike; RUN the cycle after exlike.
- **Interrupt beats exception:** wb_exc=1, excode=0x0B, and int_pend=1 (ie=1, lie[2]=is[2]=1), pc=0x1C000040 → is_exc with excode=0x00, csr_pc=0x1C000040.
- **IDLE wake-up:** wb_is_idle at pc=0x1C000200 → is_idle pulse, stall=1. Then raise ext_int[3] (inter[5] goes high SYNC_STAGES+1 cycles later). Drive is[5]=1, lie[5]=1, ie=1 → is_exc INT with csr_pc=0x1C000200, state HOLD.
- **ERTN and refetch:** ERTN at 0x1C000300 → is_ertn pulse. Then wb_refetch at 0x1C000304 → is_fetch_again pulse with csr_pc=0x1C000304, no is_exc.
- **Watchdog:** enter HOLD, hold exlike=0 → hold_timeout=1 after 15 HOLD cycles, state RUN. hold_timeout stays 1 until reset.
- **Reset mid-HOLD:** assert reset asynchronously mid-HOLD → flush, is_exc and inter go to 0 without waiting for a clock edge. After deassert, no event pulse until a new WB event.

Source files
------------

// File: rtl/exc_commit.sv
`default_nettype none
// ============================================================================
//  Module   : exc_commit
//  Purpose  : Exception / interrupt commit controller at the WB boundary.
//             Arbitrates interrupts, exceptions, ERTN, refetch and IDLE for
//             the instruction leaving WB, reports the winner to the CSR unit,
//             flushes until the CSR redirect strobe arrives, owns the IDLE
//             sleep state and synchronises the external/IPI interrupt lines.
//  Revision : 1.0  initial release
// ============================================================================
module exc_commit #(
  parameter int          SYNC_STAGES = 2,
  parameter int          HOLD_MAX    = 15,
  parameter logic [5:0]  INT_EXCODE  = 6'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  ext_int,
  input  logic        ipi_int,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic        wb_exc,
  input  logic [5:0]  wb_excode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_badv,
  input  logic        wb_is_ertn,
  input  logic        wb_refetch,
  input  logic        wb_is_idle,
  output logic        wb_ack,
  input  logic [11:0] lie,
  input  logic [11:0] is,
  input  logic        ie,
  input  logic        exlike,
  output logic [11:0] inter,
  output logic        is_exc,
  output logic [5:0]  excode,
  output logic [8:0]  esubcode,
  output logic [31:0] badvaddr,
  output logic [31:0] csr_pc,
  output logic        is_ertn,
  output logic        is_fetch_again,
  output logic        is_idle,
  output logic        flush,
  output logic        stall,
  output logic        hold_timeout
);

  // Last HOLD cycle count value before the watchdog fires.
  localparam logic [3:0] C_HOLD_LAST = 4'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_IDLE = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;
  logic        timeout_q, timeout_d;

  logic        is_exc_q, is_exc_d;
  logic        is_ertn_q, is_ertn_d;
  logic        is_fa_q, is_fa_d;
  logic        is_idle_q, is_idle_d;
  logic [5:0]  excode_q, excode_d;
  logic [8:0]  esubcode_q, esubcode_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] csr_pc_q, csr_pc_d;
  logic [31:0] idle_pc_q, idle_pc_d;

  // Bit 8 carries the IPI line, bits 7:0 the external lines.
  logic [8:0]  sync_q [SYNC_STAGES];
  logic [11:0] inter_q;

  logic        w_int_pend;

  // Synchronise the asynchronous interrupt lines and register the CSR vector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      inter_q <= '0;
    end else begin
      sync_q[0] <= {ipi_int, ext_int};
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      // Timer (bit 10) lives in the CSR unit; bits 1:0 are software interrupts.
      inter_q <= {sync_q[SYNC_STAGES-1][8], 1'b0,
                  sync_q[SYNC_STAGES-1][7:0], 2'b00};
    end
  end

  assign w_int_pend = ie & (|(lie & is));

  // Next-state, event pulse and payload selection.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = timeout_q;
    is_exc_d   = 1'b0;
    is_ertn_d  = 1'b0;
    is_fa_d    = 1'b0;
    is_idle_d  = 1'b0;
    excode_d   = excode_q;
    esubcode_d = esubcode_q;
    badvaddr_d = badvaddr_q;
    csr_pc_d   = csr_pc_q;
    idle_pc_d  = idle_pc_q;

    case (state_q)
      ST_RUN: begin
        if (wb_valid) begin
          if (w_int_pend) begin
            is_exc_d   = 1'b1;
            excode_d   = INT_EXCODE;
            esubcode_d = '0;
            csr_pc_d   = wb_pc;
            state_d    = ST_HOLD;
          end else if (wb_exc) begin
            is_exc_d   = 1'b1;
            excode_d   = wb_excode;
            esubcode_d = wb_esubcode;
            badvaddr_d = wb_badv;
            csr_pc_d   = wb_pc;
            state_d    = ST_HOLD;
          end else if (wb_is_ertn) begin
            is_ertn_d  = 1'b1;
            state_d    = ST_HOLD;
          end else if (wb_refetch) begin
            is_fa_d    = 1'b1;
            csr_pc_d   = wb_pc;
            state_d    = ST_HOLD;
          end else if (wb_is_idle) begin
            is_idle_d  = 1'b1;
            csr_pc_d   = wb_pc;
            idle_pc_d  = wb_pc;
            state_d    = ST_IDLE;
          end
        end
        hold_cnt_d = '0;
      end

      ST_IDLE: begin
        // The CSR unit derives ERA = idle pc + 4 on its own.
        if (w_int_pend) begin
          is_exc_d   = 1'b1;
          excode_d   = INT_EXCODE;
          esubcode_d = '0;
          csr_pc_d   = idle_pc_q;
          state_d    = ST_HOLD;
        end
        hold_cnt_d = '0;
      end

      ST_HOLD: begin
        if (exlike) begin
          state_d    = ST_RUN;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == C_HOLD_LAST) begin
          timeout_d  = 1'b1;
          state_d    = ST_RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end
      end

      default: begin
        state_d    = ST_RUN;
        hold_cnt_d = '0;
      end
    endcase
  end

  // State, watchdog and CSR report registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
      is_exc_q   <= 1'b0;
      is_ertn_q  <= 1'b0;
      is_fa_q    <= 1'b0;
      is_idle_q  <= 1'b0;
      excode_q   <= '0;
      esubcode_q <= '0;
      badvaddr_q <= '0;
      csr_pc_q   <= '0;
      idle_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
      is_exc_q   <= is_exc_d;
      is_ertn_q  <= is_ertn_d;
      is_fa_q    <= is_fa_d;
      is_idle_q  <= is_idle_d;
      excode_q   <= excode_d;
      esubcode_q <= esubcode_d;
      badvaddr_q <= badvaddr_d;
      csr_pc_q   <= csr_pc_d;
      idle_pc_q  <= idle_pc_d;
    end
  end

  assign wb_ack         = wb_valid & (state_q == ST_RUN);
  assign flush          = (state_q == ST_HOLD);
  assign stall          = (state_q == ST_IDLE);
  assign inter          = inter_q;
  assign is_exc         = is_exc_q;
  assign is_ertn        = is_ertn_q;
  assign is_fetch_again = is_fa_q;
  assign is_idle        = is_idle_q;
  assign excode         = excode_q;
  assign esubcode       = esubcode_q;
  assign badvaddr       = badvaddr_q;
  assign csr_pc         = csr_pc_q;
  assign hold_timeout   = timeout_q;

endmodule
`default_nettype wire
